// File: rtl/charge_scatter.sv
// -----------------------------------------------------------------------------
// charge_scatter
//   Particle-to-grid charge deposition front end for the SCATTER step.
//   Accepts one particle position per handshake and emits a stream of
//   {grid address, charge} entries for the grid charge accumulator:
//   four bilinear entries per particle, or one nearest-grid-point entry.
//   The grid is periodic, so neighbour addresses wrap at the edges.
//
//   Two register stages:
//     S1 - holds the decoded particle (cell, fractions, mode).
//     S2 - holds the particle being serialised plus a 2-bit entry index.
//   The entry address and charge are derived combinationally from S2.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     in_pos / in_ngp valid
//   in_ready     block can accept a particle this cycle
//   in_pos       {y, x} fixed-point position, PFRAC fractional bits each
//   in_ngp       1 = nearest-grid-point, 0 = bilinear
//   out_valid    scatter entry valid
//   out_ready    downstream accepts the entry
//   out_addr     row*NUM_COLS + col
//   out_charge   deposited weight, CFRAC fractional bits, unsigned
//   out_last     final entry of the current particle
//   part_cnt     (SCATTER_CNT_EN only) particles fully emitted, wraps at 2^32
//
// Configuration
//   SCATTER_CNT_EN  when defined, adds the part_cnt output and its counter.
// -----------------------------------------------------------------------------
module charge_scatter #(
  parameter int NUM_ROWS = 64,
  parameter int NUM_COLS = 64,
  parameter int PWIDTH   = 18,
  parameter int PFRAC    = 12,
  parameter int CWIDTH   = 36,
  parameter int CFRAC    = 24,
  localparam int RBITS   = $clog2(NUM_ROWS),
  localparam int CBITS   = $clog2(NUM_COLS),
  localparam int AWIDTH  = RBITS + CBITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*PWIDTH-1:0] in_pos,
  input  logic                in_ngp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AWIDTH-1:0]   out_addr,
  output logic [CWIDTH-1:0]   out_charge,
  output logic                out_last
`ifdef SCATTER_CNT_EN
  ,
  output logic [31:0]         part_cnt
`endif
);

  typedef struct packed {
    logic [PWIDTH-1:0] y;
    logic [PWIDTH-1:0] x;
  } pos_t;

  localparam int PROD_W = 2 * PFRAC + 2;
  localparam int SHIFT  = CFRAC - 2 * PFRAC;
  localparam logic [PFRAC:0]    ONE_P = {1'b1, {PFRAC{1'b0}}};
  localparam logic [CWIDTH-1:0] ONE_C = CWIDTH'(1) << CFRAC;

  pos_t pos;
  assign pos = in_pos;

  // Stage S1
  logic             s1_valid;
  logic [RBITS-1:0] s1_row;
  logic [CBITS-1:0] s1_col;
  logic [PFRAC-1:0] s1_fx, s1_fy;
  logic             s1_ngp;

  // Stage S2
  logic             s2_valid;
  logic [RBITS-1:0] s2_row;
  logic [CBITS-1:0] s2_col;
  logic [PFRAC-1:0] s2_fx, s2_fy;
  logic             s2_ngp;
  logic [1:0]       s2_idx;

  logic in_hs, out_hs, s2_done, s1_adv;

  assign out_valid = s2_valid;
  assign out_last  = s2_valid && (s2_ngp || s2_idx == 2'd3);
  assign out_hs    = out_valid && out_ready;
  assign s2_done   = out_hs && out_last;
  // S1 may hand over in the same cycle that S2 retires its last entry,
  // so a steady stream needs no bubble between particles.
  assign s1_adv    = s1_valid && (!s2_valid || s2_done);
  assign in_ready  = !s1_valid || s1_adv;
  assign in_hs     = in_valid && in_ready;

  // Control state: the only registers that need reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_idx   <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values and simulation matches hardware.
      if (in_hs)       s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv)       s2_valid <= 1'b1;
      else if (s2_done) s2_valid <= 1'b0;

      if (s1_adv)      s2_idx <= 2'd0;
      else if (out_hs) s2_idx <= s2_idx + 2'd1;
    end
  end

  // NOTE: datapath registers are deliberately left unreset; they are only
  // observed through the valid bits, and outputs are forced to zero when idle.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      // Bits above the integer field are dropped: the grid is periodic.
      s1_col <= pos.x[PFRAC +: CBITS];
      s1_fx  <= pos.x[PFRAC-1:0];
      s1_row <= pos.y[PFRAC +: RBITS];
      s1_fy  <= pos.y[PFRAC-1:0];
      s1_ngp <= in_ngp;
    end
    if (s1_adv) begin
      s2_row <= s1_row;
      s2_col <= s1_col;
      s2_fx  <= s1_fx;
      s2_fy  <= s1_fy;
      s2_ngp <= s1_ngp;
    end
  end

  // Entry generation from S2.
  logic [RBITS-1:0]  row_n;
  logic [CBITS-1:0]  col_n;
  logic [PFRAC:0]    wx, wy;
  logic [PROD_W-1:0] prod;
  logic [CWIDTH-1:0] charge;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    row_n  = s2_row;
    col_n  = s2_col;
    wx     = '0;
    wy     = '0;
    prod   = '0;
    charge = '0;
    if (s2_ngp) begin
      // Round to the nearest node: fraction >= one/2 is exactly its MSB.
      row_n  = s2_row + RBITS'(s2_fy[PFRAC-1]);
      col_n  = s2_col + CBITS'(s2_fx[PFRAC-1]);
      charge = ONE_C;
    end else begin
      // idx[0] selects the col+1 neighbour, idx[1] the row+1 neighbour;
      // this yields the order (r,c), (r,c+1), (r+1,c), (r+1,c+1).
      // Additions wrap naturally in the field width.
      row_n  = s2_row + RBITS'(s2_idx[1]);
      col_n  = s2_col + CBITS'(s2_idx[0]);
      wx     = s2_idx[0] ? {1'b0, s2_fx} : ONE_P - {1'b0, s2_fx};
      wy     = s2_idx[1] ? {1'b0, s2_fy} : ONE_P - {1'b0, s2_fy};
      prod   = PROD_W'(wx) * PROD_W'(wy);
      charge = CWIDTH'(prod) << SHIFT;
    end
  end

  assign out_addr   = s2_valid ? {row_n, col_n} : '0;
  assign out_charge = s2_valid ? charge : '0;

`ifdef SCATTER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)          part_cnt <= '0;
    else if (s2_done) part_cnt <= part_cnt + 32'd1;
  end
`endif

endmodule
